// File: rtl/nibble_packer.sv
// Packs a nibble stream into bytes (first nibble in the high half) and buffers
// them in a first-word-fall-through FIFO with a sticky overflow flag.
module nibble_packer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          clr,
  input  logic [3:0]    din,
  input  logic          din_vld,
  input  logic          flush,
  output logic [7:0]    dout,
  output logic          dout_vld,
  input  logic          dout_rdy,
  output logic          full,
  output logic [AW:0]   cnt,
  output logic          half,
  output logic          ovf
);

  // Byte handshake: a byte transfers on every rising edge where
  // dout_vld & dout_rdy; dout_vld never depends on dout_rdy.

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_HALF  = 1'b1
  } state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_t          state;
  logic [3:0]      hold;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [AW:0]     cnt_q;
  logic            ovf_q;

  logic            push_req;
  logic [7:0]      push_byte;
  logic            pop;
  logic            push_ok;

  always_comb begin
    push_req  = 1'b0;
    push_byte = {din, 4'h0};
    case (state)
      S_EMPTY: begin
        if (din_vld && flush) begin
          push_req  = 1'b1;
          push_byte = {din, 4'h0};
        end
      end
      S_HALF: begin
        // A real low nibble wins over flush padding.
        if (din_vld) begin
          push_req  = 1'b1;
          push_byte = {hold, din};
        end else if (flush) begin
          push_req  = 1'b1;
          push_byte = {hold, 4'h0};
        end
      end
      default: ;
    endcase
  end

  assign full     = (cnt_q == FULL_CNT);
  assign dout_vld = (cnt_q != '0);
  assign cnt      = cnt_q;
  assign half     = (state == S_HALF);
  assign ovf      = ovf_q;
  assign dout     = dout_vld ? mem[rptr] : 8'h00;

  assign pop     = dout_vld & dout_rdy;
  // When full, a push only fits if the head leaves in the same cycle.
  assign push_ok = push_req & (~full | pop);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= S_EMPTY;
      hold  <= 4'h0;
      wptr  <= '0;
      rptr  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (clr) begin
      state <= S_EMPTY;
      hold  <= 4'h0;
      wptr  <= '0;
      rptr  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (din_vld && !flush) begin
            hold  <= din;
            state <= S_HALF;
          end
        end
        S_HALF: begin
          if (din_vld || flush) state <= S_EMPTY;
        end
        default: state <= S_EMPTY;
      endcase

      if (push_ok) wptr <= wptr + AW'(1);
      if (pop)     rptr <= rptr + AW'(1);

      case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase

      if (push_req && !push_ok) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst && !clr && push_ok) mem[wptr] <= push_byte;
  end

endmodule

// File: doc/nibble_packer.md
Name: nibble_packer

Overview:
- Sits directly downstream of the serial-to-parallel receiver and consumes its 4-bit dout/dout_vld stream.
- Packs consecutive nibble pairs into bytes, with the first nibble placed in the high half.
- Buffers completed bytes in a small FIFO and presents them on a valid/ready byte interface to the next stage.
- Provides a flush for odd-length nibble streams and a sticky overflow flag.

Parameters:
DEPTH, 4, FIFO depth in bytes; power of two, >= 2.
AW, 2, pointer width = log2(DEPTH); set consistently with DEPTH.

Ports:
clk  input  1  system clock; all state updates on rising edge
n_rst  input  1  asynchronous active-low reset
clr  input  1  synchronous clear: empties FIFO, drops pending nibble, clears ovf
din  input  4  nibble from the serial-to-parallel stage
din_vld  input  1  one-cycle qualifier for din; every asserted cycle is one nibble
flush  input  1  pad a pending half-byte with 4'b0000 and push it
dout  output  8  byte at FIFO head
dout_vld  output  1  FIFO not empty
dout_rdy  input  1  downstream accepts dout when dout_vld & dout_rdy
full  output  1  FIFO holds DEPTH bytes
cnt  output  AW+1  number of bytes held, 0..DEPTH
half  output  1  a high nibble is held, waiting for its partner
ovf  output  1  sticky: a byte was dropped because the FIFO was full

Behaviour:
- Reset (n_rst low, asynchronous):
  - Pointers = 0, cnt = 0, half = 0, hold register = 0, ovf = 0.
  - dout_vld = 0, full = 0, dout = 8'h00.
  - FIFO memory need not be reset.
- clr:
  - Same effect as reset, applied at the clock edge.
  - Has priority over din_vld, flush and pop in the same cycle.
- Packer, two states: EMPTY (half = 0) and HALF (half = 1).
  - EMPTY & din_vld & !flush: hold <= din, go to HALF; no push.
  - EMPTY & din_vld & flush: push {din, 4'b0000}; stay in EMPTY.
  - EMPTY & !din_vld & flush: no-op.
  - HALF & din_vld: push {hold, din}, go to EMPTY. flush in the same cycle is ignored; nothing is left pending.
  - HALF & !din_vld & flush: push {hold, 4'b0000}, go to EMPTY.
  - No din_vld and no flush: hold state.
- Latency: a byte pushed at edge k has dout_vld = 1 and dout valid after edge k. This is one cycle after the completing nibble's cycle.
- FIFO behaviour:
  - First-word fall-through: dout = mem[rptr] whenever dout_vld = 1.
  - dout value is don't-care when dout_vld = 0; the bench must not check it.
  - pop = dout_vld & dout_rdy; advances rptr at the edge.
  - Pointers wrap modulo DEPTH.
  - push & !pop: cnt + 1. pop & !push: cnt - 1. Both: cnt unchanged.
  - Push when full without a simultaneous pop: the byte is dropped, ovf <= 1, pointers and cnt unchanged. The packer still returns to EMPTY, so the nibble pair is consumed.
  - Push when full with a simultaneous pop: the push succeeds, cnt stays at DEPTH, ovf unchanged.
  - Push when empty with no pop possible: cnt becomes 1.
  - dout_rdy while empty: no effect; no underflow.
- Status outputs:
  - full = (cnt == DEPTH); dout_vld = (cnt != 0). Both are derived from registered cnt with no combinational path from inputs.
  - ovf stays at 1 until reset or clr.
- No combinational path from din, din_vld, flush or dout_rdy to any output.
- Reset or clr mid-stream discards the pending nibble and all buffered bytes. The first nibble after release is treated as a high nibble.

Test Plan:
1. Reset, then din = 4'b1001 (vld), din = 4'b0011 (vld) on consecutive cycles, dout_rdy = 1: half is 1 after the first nibble; one cycle after the second nibble dout_vld = 1 with dout = 8'h93; the byte pops and cnt returns to 0.
2. dout_rdy = 0; push nibbles 1,2,3,4,5,6,7,8,9,A (5 bytes, DEPTH = 4): cnt = 4 and full = 1 after the 4th byte; the 5th byte 8'h9A is dropped and ovf = 1. Raising dout_rdy then yields 8'h12, 8'h34, 8'h56, 8'h78 in order, then dout_vld = 0. ovf remains 1.
3. Odd stream: din = 4'hC (vld), then flush alone: dout = 8'hC0. Then flush with din_vld and din = 4'h5 from EMPTY: dout = 8'h50. A flush while EMPTY with no din_vld leaves cnt unchanged.
4. FIFO full with dout_rdy = 1 while a byte completes (simultaneous push/pop): cnt stays 4, ovf stays 0, and output order is preserved across pointer wrap (bytes 8'h11..8'h66 stream in and out correctly).
5. Assert n_rst low asynchronously mid-cycle while half = 1 and cnt = 2: dout_vld, half, cnt and ovf go to 0 immediately, without waiting for a clock edge. After release, nibbles A then B give 8'hAB.
6. clr asserted in the same cycle as din_vld with half = 1 and a pending pop: after the edge cnt = 0, half = 0, ovf = 0, and no byte is pushed.
